// File: rtl/fifo_spi_sequencer.sv
// Command sequencer: pops headers/payload from FIFO A, runs SPI transfers, pushes results to FIFO B.
// Optional macro SEQ_DONE_WORD_EN adds a completion word to FIFO B after every WRITE/READ.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a header in FIFO A
// HDR_RD   | header word on FIFOA_OUT, latch opcode and N
// DECODE   | dispatch on opcode, handle N = 0 and illegal opcodes
// DAT_RD   | WRITE: wait for a payload word, pop it
// DAT_LAT  | WRITE: latch payload word into spi_tx
// SPI_GO   | wait for SPI master idle, pulse spi_start
// SPI_WAIT | wait for spi_done
// PUSH     | write FIFOB_IN into FIFO B (read data, status or completion word)
// WAIT_STA | poll selected chip status with a down-counting timeout
module fifo_spi_sequencer #(
    parameter int TIMEOUT_W = 16,
    parameter int CNT_W     = 16
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [31:0] FIFOA_OUT,
    input  logic        FIFOA_empty,
    output logic        FIFOA_ren,
    output logic [31:0] FIFOB_IN,
    input  logic        FIFOB_full,
    output logic        FIFOB_wen,
    output logic [31:0] spi_tx,
    output logic        spi_start,
    input  logic        spi_busy,
    input  logic        spi_done,
    input  logic [31:0] spi_rx,
    input  logic        sta_wei,
    input  logic        sta_act,
    output logic        busy,
    output logic        err,
    output logic        Triggered
);
    typedef enum logic [3:0] {
        IDLE, HDR_RD, DECODE, DAT_RD, DAT_LAT, SPI_GO, SPI_WAIT, PUSH, WAIT_STA
    } state_t;

    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;
    localparam logic [3:0] OP_STA   = 4'h3;

    state_t               state, state_nxt;
    logic [3:0]           op, op_nxt;
    logic [CNT_W-1:0]     n_q, n_nxt, cnt, cnt_nxt;
    logic [TIMEOUT_W-1:0] tmr, tmr_nxt;
    logic                 fin, fin_nxt, err_nxt, armed, complete, sta_sel;
    logic [31:0]          tx_nxt, push_nxt;
    logic                 unused_hdr;

    assign unused_hdr = ^FIFOA_OUT[27:CNT_W];
    assign busy       = (state != IDLE);
    assign sta_sel    = n_q[0];

`ifdef SEQ_DONE_WORD_EN
    logic [31:0] n_ext;
    logic [31:0] done_word;
    assign n_ext     = 32'(n_q);
    assign done_word = {8'hD0, 4'h0, op, n_ext[15:0]};
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= '0;
            n_q      <= '0;
            cnt      <= '0;
            tmr      <= '0;
            fin      <= 1'b0;
            err      <= 1'b0;
            spi_tx   <= '0;
            FIFOB_IN <= '0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nxt;
            op       <= op_nxt;
            n_q      <= n_nxt;
            cnt      <= cnt_nxt;
            tmr      <= tmr_nxt;
            fin      <= fin_nxt;
            err      <= err_nxt;
            spi_tx   <= tx_nxt;
            FIFOB_IN <= push_nxt;
            armed    <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        n_nxt     = n_q;
        cnt_nxt   = cnt;
        tmr_nxt   = tmr;
        fin_nxt   = fin;
        err_nxt   = err;
        tx_nxt    = spi_tx;
        push_nxt  = FIFOB_IN;
        FIFOA_ren = 1'b0;
        FIFOB_wen = 1'b0;
        spi_start = 1'b0;
        Triggered = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                // armed keeps FIFO A untouched while reset is held
                if (armed && !FIFOA_empty) begin
                    FIFOA_ren = 1'b1;
                    state_nxt = HDR_RD;
                end
            end
            HDR_RD: begin
                op_nxt    = FIFOA_OUT[31:28];
                n_nxt     = FIFOA_OUT[CNT_W-1:0];
                cnt_nxt   = FIFOA_OUT[CNT_W-1:0];
                fin_nxt   = 1'b0;
                state_nxt = DECODE;
            end
            DECODE: begin
                case (op)
                    OP_WRITE, OP_READ: begin
                        if (cnt == '0) begin
                            complete = 1'b1;
                        end else if (op == OP_WRITE) begin
                            state_nxt = DAT_RD;
                        end else begin
                            tx_nxt    = '0;
                            state_nxt = SPI_GO;
                        end
                    end
                    OP_STA: begin
                        tmr_nxt   = '1;
                        state_nxt = WAIT_STA;
                    end
                    default: begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                endcase
            end
            DAT_RD: begin
                if (!FIFOA_empty) begin
                    FIFOA_ren = 1'b1;
                    state_nxt = DAT_LAT;
                end
            end
            DAT_LAT: begin
                tx_nxt    = FIFOA_OUT;
                state_nxt = SPI_GO;
            end
            SPI_GO: begin
                if (!spi_busy) begin
                    spi_start = 1'b1;
                    state_nxt = SPI_WAIT;
                end
            end
            SPI_WAIT: begin
                if (spi_done) begin
                    if (op == OP_READ) begin
                        push_nxt  = spi_rx;
                        state_nxt = PUSH;
                    end else if (cnt == CNT_W'(1)) begin
                        complete = 1'b1;
                    end else begin
                        cnt_nxt   = cnt - CNT_W'(1);
                        state_nxt = DAT_RD;
                    end
                end
            end
            PUSH: begin
                if (!FIFOB_full) begin
                    FIFOB_wen = 1'b1;
                    if (fin) begin
                        Triggered = 1'b1;
                        state_nxt = IDLE;
                    end else if (cnt == CNT_W'(1)) begin
                        complete = 1'b1;
                    end else begin
                        cnt_nxt   = cnt - CNT_W'(1);
                        state_nxt = SPI_GO;
                    end
                end
            end
            WAIT_STA: begin
                if (sta_sel ? sta_wei : sta_act) begin
                    push_nxt  = {16'h5A00, 15'd0, sta_sel};
                    fin_nxt   = 1'b1;
                    state_nxt = PUSH;
                end else if (tmr == '0) begin
                    push_nxt  = {16'hDEAD, 15'd0, sta_sel};
                    err_nxt   = 1'b1;
                    fin_nxt   = 1'b1;
                    state_nxt = PUSH;
                end else begin
                    tmr_nxt = tmr - TIMEOUT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (complete) begin
            cnt_nxt = '0;
`ifdef SEQ_DONE_WORD_EN
            push_nxt  = done_word;
            fin_nxt   = 1'b1;
            state_nxt = PUSH;
`else
            Triggered = 1'b1;
            state_nxt = IDLE;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_spi_sequencer.sv
// Scoreboard bench for fifo_spi_sequencer: FIFO A/B and SPI master models with expected-value queues.
// Honours SEQ_DONE_WORD_EN the same way as the design.
module tb_fifo_spi_sequencer;
    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] FIFOA_OUT = '0;
    logic        FIFOA_empty = 1'b1;
    logic        FIFOA_ren;
    logic [31:0] FIFOB_IN;
    logic        FIFOB_full = 1'b0;
    logic        FIFOB_wen;
    logic [31:0] spi_tx;
    logic        spi_start;
    logic        spi_busy = 1'b0;
    logic        spi_done = 1'b0;
    logic [31:0] spi_rx = '0;
    logic        sta_wei = 1'b0;
    logic        sta_act = 1'b0;
    logic        busy, err, Triggered;

    int total = 0;
    int bad = 0;
    int trig_cnt = 0;
    int push_cnt = 0;
    logic [31:0] a_q[$];
    logic [31:0] rx_q[$];
    logic [31:0] exp_tx[$];
    logic [31:0] exp_b[$];

    fifo_spi_sequencer dut (
        .CLK(CLK), .rst_n(rst_n),
        .FIFOA_OUT(FIFOA_OUT), .FIFOA_empty(FIFOA_empty), .FIFOA_ren(FIFOA_ren),
        .FIFOB_IN(FIFOB_IN), .FIFOB_full(FIFOB_full), .FIFOB_wen(FIFOB_wen),
        .spi_tx(spi_tx), .spi_start(spi_start), .spi_busy(spi_busy),
        .spi_done(spi_done), .spi_rx(spi_rx),
        .sta_wei(sta_wei), .sta_act(sta_act),
        .busy(busy), .err(err), .Triggered(Triggered)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h expected no such event", nm, act);
    endtask

    function automatic logic [31:0] outs();
        return 32'({FIFOA_ren, FIFOB_wen, spi_start, busy, err, Triggered}) | FIFOB_IN | spi_tx;
    endfunction

    // FIFO A: standard-mode read, data valid the cycle after ren
    initial begin
        logic pop;
        forever begin
            @(negedge CLK);
            pop = FIFOA_ren;
            @(posedge CLK);
            #1;
            if (pop) begin
                if (a_q.size() == 0) fail("fifoa_underflow", 32'd0);
                else FIFOA_OUT = a_q.pop_front();
            end
            FIFOA_empty = (a_q.size() == 0);
        end
    end

    // SPI master: 4-cycle busy, done pulse carries the next rx word
    initial begin
        forever begin
            @(negedge CLK);
            if (spi_start && !spi_busy) begin
                if (exp_tx.size() == 0) fail("unexpected_spi_start", spi_tx);
                else chk("spi_tx", spi_tx, exp_tx.pop_front());
                @(posedge CLK);
                #1 spi_busy = 1'b1;
                repeat (4) @(posedge CLK);
                #1;
                spi_busy = 1'b0;
                spi_done = 1'b1;
                spi_rx   = (rx_q.size() != 0) ? rx_q.pop_front() : 32'hFFFF_FFFF;
                @(posedge CLK);
                #1 spi_done = 1'b0;
            end
        end
    end

    // monitor: FIFO B scoreboard and protocol checks
    always @(negedge CLK) begin
        if (Triggered) trig_cnt++;
        if (spi_start && spi_busy) fail("start_while_busy", spi_tx);
        if (FIFOA_ren && FIFOB_wen) fail("ren_wen_overlap", FIFOB_IN);
        if (FIFOB_wen) begin
            if (FIFOB_full) fail("wen_while_full", FIFOB_IN);
            else if (exp_b.size() == 0) fail("unexpected_fifob_push", FIFOB_IN);
            else begin
                push_cnt++;
                chk("fifob_data", FIFOB_IN, exp_b.pop_front());
            end
        end
    end

    task automatic run_idle(input string nm, input int budget);
        int n = 0;
        repeat (4) @(negedge CLK);
        while ((busy || a_q.size() != 0 || spi_busy || spi_done) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, "_finished"}, 32'(n < budget), 32'd1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic drained(input string nm);
        chk({nm, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
        chk({nm, "_b_left"}, 32'(exp_b.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #1 rst_n = 1'b0;
        @(negedge CLK);
        chk("reset_outputs_zero", outs(), 32'd0);
        repeat (2) @(posedge CLK);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int t0, p0;
        repeat (3) @(negedge CLK);
        chk("reset_state", outs(), 32'd0);
        @(posedge CLK);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge CLK);
        chk("post_reset_idle", outs(), 32'd0);

        // WRITE of two words
        t0 = trig_cnt;
        exp_tx.push_back(32'hA5A5_0001);
        exp_tx.push_back(32'h1234_5678);
`ifdef SEQ_DONE_WORD_EN
        exp_b.push_back(32'hD010_0002);
`endif
        a_q.push_back(32'h1000_0002);
        a_q.push_back(32'hA5A5_0001);
        a_q.push_back(32'h1234_5678);
        run_idle("write2", 200);
        chk("write2_trig", 32'(trig_cnt - t0), 32'd1);
        chk("write2_err", 32'(err), 32'd0);
        drained("write2");

        // READ of three words
        t0 = trig_cnt;
        for (int i = 1; i <= 3; i++) begin
            rx_q.push_back(32'(i));
            exp_tx.push_back(32'h0);
            exp_b.push_back(32'(i));
        end
`ifdef SEQ_DONE_WORD_EN
        exp_b.push_back(32'hD020_0003);
`endif
        a_q.push_back(32'h2000_0003);
        run_idle("read3", 300);
        chk("read3_trig", 32'(trig_cnt - t0), 32'd1);
        drained("read3");

        // READ of three words with FIFO B full ahead of the 2nd push
        t0 = trig_cnt;
        p0 = push_cnt;
        for (int i = 1; i <= 3; i++) begin
            rx_q.push_back(32'(i));
            exp_tx.push_back(32'h0);
            exp_b.push_back(32'(i));
        end
`ifdef SEQ_DONE_WORD_EN
        exp_b.push_back(32'hD020_0003);
`endif
        a_q.push_back(32'h2000_0003);
        fork
            run_idle("read3_stall", 400);
            begin
                int n = 0;
                while (push_cnt == p0 && n < 200) begin
                    @(negedge CLK);
                    n++;
                end
                @(posedge CLK);
                #1 FIFOB_full = 1'b1;
                repeat (12) @(posedge CLK);
                #1;
                chk("stall_no_push", 32'(push_cnt - p0), 32'd1);
                FIFOB_full = 1'b0;
            end
        join
        chk("read3_stall_trig", 32'(trig_cnt - t0), 32'd1);
        drained("read3_stall");

        // WAIT_STA on sta_wei rising after 100 cycles
        t0 = trig_cnt;
        exp_b.push_back(32'h5A00_0001);
        a_q.push_back(32'h3000_0001);
        fork
            run_idle("sta_wei", 400);
            begin
                repeat (100) @(negedge CLK);
                sta_wei = 1'b1;
            end
        join
        sta_wei = 1'b0;
        chk("sta_wei_trig", 32'(trig_cnt - t0), 32'd1);
        chk("sta_wei_err", 32'(err), 32'd0);
        drained("sta_wei");

        // WRITE with payload arriving 50 cycles late
        t0 = trig_cnt;
        exp_tx.push_back(32'hCAFE_F00D);
`ifdef SEQ_DONE_WORD_EN
        exp_b.push_back(32'hD010_0001);
`endif
        a_q.push_back(32'h1000_0001);
        repeat (50) @(negedge CLK);
        chk("late_still_busy", 32'(busy), 32'd1);
        chk("late_no_spi_yet", 32'(exp_tx.size()), 32'd1);
        a_q.push_back(32'hCAFE_F00D);
        run_idle("late", 200);
        chk("late_trig", 32'(trig_cnt - t0), 32'd1);
        drained("late");

        // reset during SPI_WAIT of a READ
        t0 = trig_cnt;
        rx_q.push_back(32'h0BAD_0BAD);
        exp_tx.push_back(32'h0);
        a_q.push_back(32'h2000_0001);
        begin
            int n = 0;
            while (!spi_busy && n < 50) begin
                @(negedge CLK);
                n++;
            end
            chk("rst_reached_spi", 32'(spi_busy), 32'd1);
        end
        pulse_reset();
        repeat (20) @(negedge CLK);
        chk("rst_idle", 32'(busy), 32'd0);
        chk("rst_no_trig", 32'(trig_cnt - t0), 32'd0);
        drained("rst");

        // illegal opcode followed by an empty WRITE
        t0 = trig_cnt;
`ifdef SEQ_DONE_WORD_EN
        exp_b.push_back(32'hD010_0000);
`endif
        a_q.push_back(32'h7000_0005);
        a_q.push_back(32'h1000_0000);
        run_idle("illegal", 200);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_trig", 32'(trig_cnt - t0), 32'd1);
        drained("illegal");

        // WAIT_STA timeout with sta_wei held low
        pulse_reset();
        repeat (2) @(negedge CLK);
        chk("err_cleared", 32'(err), 32'd0);
        t0 = trig_cnt;
        exp_b.push_back(32'hDEAD_0001);
        a_q.push_back(32'h3000_0001);
        repeat (1000) @(negedge CLK);
        chk("timeout_not_early", 32'(exp_b.size()), 32'd1);
        run_idle("timeout", 70000);
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_trig", 32'(trig_cnt - t0), 32'd1);
        drained("timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
